acc_drain_requant: RTL and testbench
====================================

Name: acc_drain_requant

Overview:
Downstream stage of a row of mac_unit PEs. On a start pulse it snapshots all NUM_PE 20-bit signed accumulators and issues a one-cycle clear to the PEs so they can begin the next tile. It then requantizes each value (rounding arithmetic right shift, optional ReLU, saturation to int8). The results stream out one per beat over a valid/ready interface to the output buffer.

Parameters:
NUM_PE, 4, number of accumulators captured and drained per start
ACC_W, 20, accumulator width (signed, matches mac_unit)
OUT_W, 8, output width (signed)
IDX_W, $clog2(NUM_PE), beat index width

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-high; clears all state and outputs
start  in  1  request snapshot+drain; sampled only in IDLE
acc_flat  in  NUM_PE*ACC_W  packed signed accumulators, PE k at bits [k*ACC_W +: ACC_W]
shift_amt  in  5  right-shift amount 0..19, latched on start
relu_en  in  1  clamp negatives to 0, latched on start
clear_acc_out  out  1  one-cycle pulse to PE clear_acc inputs
busy  out  1  high from capture until done
out_valid  out  1  beat valid
out_ready  in  1  downstream accept
out_data  out  OUT_W  signed requantized value
out_index  out  IDX_W  PE index of current beat
out_last  out  1  high on beat NUM_PE-1
done  out  1  one-cycle pulse after final beat accepted

Behaviour:
- Reset (async assert): state=IDLE. All outputs are 0: busy, clear_acc_out, out_valid, out_data, out_index, out_last, done. Bank and config are cleared. Reset mid-drain aborts with no further beats and no clear pulse.
- States: IDLE, LOAD, DRAIN.
- IDLE: on posedge with start=1, bank<=acc_flat, shift_amt/relu_en are latched, busy<=1, clear_acc_out<=1, state<=LOAD. start in any other state is ignored.
- LOAD (exactly 1 cycle, clear_acc_out high): out_data<=rq(bank[0]), out_index<=0, out_last<=(NUM_PE==1), out_valid<=1, clear_acc_out<=0, state<=DRAIN.
- DRAIN: a beat transfers on posedge with out_valid&&out_ready.
  - Transfer of a non-last beat: load rq(bank[idx+1]), increment out_index, update out_last.
  - Transfer of the last beat: out_valid<=0, busy<=0, done<=1 for 1 cycle, state<=IDLE.
  - With out_valid && !out_ready: out_data, out_index and out_last hold stable.
  - out_valid never drops before its beat transfers.
- Latency: start sampled at edge T0. clear_acc_out is high during T0..T1. First beat is valid from T1. With out_ready held high, beats transfer at T2..T(1+NUM_PE), and done is high the cycle after the last transfer.
- Back-to-back: start may be sampled in the same cycle done is high (state already IDLE).
- rq(a), evaluated in ACC_W+2 bits signed:
  - s=shift_amt. If s>0, t=(a + (1<<(s-1))) >>> s, i.e. round half toward +inf. If s=0, t=a.
  - If relu_en and t<0, t=0.
  - Saturate t to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- shift_amt>19 is treated as 19.
- The bank is a snapshot: acc_flat changes after T0 do not affect outputs.
- Upstream must hold PE enable low during the LOAD cycle.

Test Plan:
- Basic: acc={15,23,-42,100}, shift 0, relu 0, ready=1 -> clear_acc_out high for 1 cycle, out_data 15,23,-42,100 with index 0..3 on 4 consecutive cycles, out_last only on 100, done 1 cycle later.
- Saturation/rounding: acc={0x7FFFF,0x80000,6,-6}, shift 12 -> 127,-128,0,0. Same acc with shift 2 -> 127,-128,2,-1. acc={5,-5,3,-3}, shift 1 -> 3,-2,2,-1.
- ReLU: acc={-42,42,-1,0}, shift 0, relu 1 -> 0,42,0,0.
- Backpressure: ready low for 3 cycles while beat 1 is valid -> out_data/out_index stable and no beat skipped. Total of 4 transfers, done once.
- Start while busy: second start pulse during DRAIN -> ignored, no extra clear_acc_out, 4 beats only. A start on the cycle done is high -> new capture proceeds.
- Reset mid-drain: assert reset after beat 1 -> all outputs 0 immediately (async). After release, out_valid stays 0 until a new start.

Source files
------------

// File: rtl/acc_drain_requant.sv
// Snapshots NUM_PE accumulators on start, pulses clear to the PEs, then streams
// requantized int8 results one beat per transfer. Backpressure: a beat holds until accepted.
module acc_drain_requant #(
  parameter int NUM_PE = 4,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 8,
  parameter int IDX_W  = $clog2(NUM_PE)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_PE*ACC_W-1:0] acc_flat,
  input  logic [4:0]              shift_amt,
  input  logic                    relu_en,
  output logic                    clear_acc_out,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [IDX_W-1:0]        out_index,
  output logic                    out_last,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  localparam int XW = ACC_W + 2;
  localparam logic signed [XW-1:0] SAT_HI = XW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_LO = ~SAT_HI;

  state_t                    state_q, state_d;
  logic [NUM_PE*ACC_W-1:0]   bank_q, bank_d;
  logic [4:0]                shift_q, shift_d;
  logic                      relu_q, relu_d;
  logic                      busy_q, busy_d;
  logic                      clear_q, clear_d;
  logic                      valid_q, valid_d;
  logic signed [OUT_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]          index_q, index_d;
  logic                      last_q, last_d;
  logic                      done_q, done_d;
  logic [IDX_W-1:0]          nxt_idx;

  // Rounding is half toward +inf: add half an LSB of the result before the arithmetic shift.
  function automatic logic signed [OUT_W-1:0] rq(input logic [ACC_W-1:0] a,
                                                 input logic [4:0] s,
                                                 input logic relu);
    logic [4:0]              sc;
    logic signed [XW-1:0]    t;
    logic signed [XW-1:0]    rnd;
    sc  = (s > 5'(ACC_W - 1)) ? 5'(ACC_W - 1) : s;
    t   = {{2{a[ACC_W-1]}}, a};
    rnd = '0;
    if (sc != 5'd0) begin
      rnd[sc - 5'd1] = 1'b1;
      t = (t + rnd) >>> sc;
    end
    if (relu && t[XW-1]) t = '0;
    if (t > SAT_HI)      t = SAT_HI;
    else if (t < SAT_LO) t = SAT_LO;
    return t[OUT_W-1:0];
  endfunction

  function automatic logic [ACC_W-1:0] bank_at(input logic [NUM_PE*ACC_W-1:0] b,
                                               input logic [IDX_W-1:0] i);
    return b[i*ACC_W +: ACC_W];
  endfunction

  assign nxt_idx = index_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    shift_d = shift_q;
    relu_d  = relu_q;
    busy_d  = busy_q;
    clear_d = 1'b0;
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bank_d  = acc_flat;
          shift_d = shift_amt;
          relu_d  = relu_en;
          busy_d  = 1'b1;
          clear_d = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        data_d  = rq(bank_at(bank_q, '0), shift_q, relu_q);
        index_d = '0;
        last_d  = (NUM_PE == 1);
        valid_d = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (valid_q && out_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            data_d  = rq(bank_at(bank_q, nxt_idx), shift_q, relu_q);
            index_d = nxt_idx;
            last_d  = (nxt_idx == IDX_W'(NUM_PE - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bank_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      busy_q  <= 1'b0;
      clear_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      shift_q <= shift_d;
      relu_q  <= relu_d;
      busy_q  <= busy_d;
      clear_q <= clear_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign clear_acc_out = clear_q;
  assign busy          = busy_q;
  assign out_valid     = valid_q;
  assign out_data      = data_q;
  assign out_index     = index_q;
  assign out_last      = last_q;
  assign done          = done_q;

endmodule

// File: tb/tb_acc_drain_requant.sv
// Directed bench for acc_drain_requant: hand-computed requant vectors, backpressure,
// start filtering, back-to-back capture and asynchronous reset.
module tb_acc_drain_requant;

  localparam int NUM_PE = 4;
  localparam int ACC_W  = 20;
  localparam int OUT_W  = 8;
  localparam int IDX_W  = 2;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    start;
  logic [NUM_PE*ACC_W-1:0] acc_flat;
  logic [4:0]              shift_amt;
  logic                    relu_en;
  logic                    clear_acc_out;
  logic                    busy;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [IDX_W-1:0]        out_index;
  logic                    out_last;
  logic                    done;

  int checks   = 0;
  int failures = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int clr_cnt  = 0;

  acc_drain_requant #(.NUM_PE(NUM_PE), .ACC_W(ACC_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) dut (
    .clock(clock), .reset(reset), .start(start), .acc_flat(acc_flat),
    .shift_amt(shift_amt), .relu_en(relu_en), .clear_acc_out(clear_acc_out),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (out_valid && out_ready) xfer_cnt++;
    if (done) done_cnt++;
    if (clear_acc_out) clr_cnt++;
  end

  function automatic logic [NUM_PE*ACC_W-1:0] pack4(input int v0, input int v1,
                                                    input int v2, input int v3);
    return {v3[ACC_W-1:0], v2[ACC_W-1:0], v1[ACC_W-1:0], v0[ACC_W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one start pulse, then scrambles acc_flat to prove the snapshot is used.
  task automatic begin_tile(input int a0, input int a1, input int a2, input int a3,
                            input int sh, input bit relu);
    acc_flat  = pack4(a0, a1, a2, a3);
    shift_amt = 5'(sh);
    relu_en   = relu;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    acc_flat  = pack4(77, -77, 1000, -1000);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    acc_flat = '0; shift_amt = '0; relu_en = 1'b0;
    #12;
    checks++;
    if ({busy, clear_acc_out, out_valid, done, out_last, out_index, out_data} !== '0)
      begin failures++; $display("FAIL reset_state: busy=%b clr=%b vld=%b done=%b last=%b idx=%0d data=%0d required all 0",
                                 busy, clear_acc_out, out_valid, done, out_last, out_index, out_data); end
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int exp_d[4] = '{15, 23, -42, 100};
    logic [OUT_W-1:0] e;
    xfer_cnt = 0; done_cnt = 0; clr_cnt = 0;
    out_ready = 1'b1;
    begin_tile(15, 23, -42, 100, 0, 1'b0);
    checks++;
    if (clear_acc_out !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0)
      begin failures++; $display("FAIL basic_capture: clr=%b busy=%b vld=%b required 1 1 0", clear_acc_out, busy, out_valid); end
    tick();
    checks++;
    if (clear_acc_out !== 1'b0)
      begin failures++; $display("FAIL basic_clear_width: clr=%b required 0", clear_acc_out); end
    for (int k = 0; k < NUM_PE; k++) begin
      e = OUT_W'(exp_d[k]);
      checks++;
      if (out_valid !== 1'b1 || out_data !== e || out_index !== IDX_W'(k) || out_last !== (k == NUM_PE - 1))
        begin failures++; $display("FAIL basic_beat%0d: vld=%b data=%0d idx=%0d last=%b required 1 %0d %0d %b",
                                   k, out_valid, out_data, out_index, out_last, $signed(e), k, k == NUM_PE - 1); end
      tick();
    end
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      begin failures++; $display("FAIL basic_done: done=%b vld=%b busy=%b required 1 0 0", done, out_valid, busy); end
    tick();
    checks++;
    if (done !== 1'b0 || xfer_cnt != 4 || clr_cnt != 1)
      begin failures++; $display("FAIL basic_counts: done=%b xfers=%0d clears=%0d required 0 4 1", done, xfer_cnt, clr_cnt); end
  endtask

  task automatic test_sat_round();
    int acc_v[4][4] = '{'{'h7FFFF, 'h80000, 6, -6}, '{'h7FFFF, 'h80000, 6, -6},
                        '{5, -5, 3, -3},            '{1000, -1000, 'h7FFFF, 3}};
    int sh_v[4]     = '{12, 2, 1, 31};
    int exp_v[4][4] = '{'{127, -128, 0, 0}, '{127, -128, 2, -1},
                        '{3, -2, 2, -1},    '{0, 0, 1, 0}};
    logic [OUT_W-1:0] e;
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      begin_tile(acc_v[v][0], acc_v[v][1], acc_v[v][2], acc_v[v][3], sh_v[v], 1'b0);
      tick();
      for (int k = 0; k < NUM_PE; k++) begin
        e = OUT_W'(exp_v[v][k]);
        checks++;
        if (out_valid !== 1'b1 || out_data !== e || out_index !== IDX_W'(k))
          begin failures++; $display("FAIL satround_v%0d_beat%0d: vld=%b data=%0d idx=%0d required 1 %0d %0d",
                                     v, k, out_valid, out_data, out_index, $signed(e), k); end
        tick();
      end
      tick();
    end
  endtask

  task automatic test_relu();
    int exp_d[4] = '{0, 42, 0, 0};
    logic [OUT_W-1:0] e;
    out_ready = 1'b1;
    begin_tile(-42, 42, -1, 0, 0, 1'b1);
    tick();
    for (int k = 0; k < NUM_PE; k++) begin
      e = OUT_W'(exp_d[k]);
      checks++;
      if (out_valid !== 1'b1 || out_data !== e)
        begin failures++; $display("FAIL relu_beat%0d: vld=%b data=%0d required 1 %0d", k, out_valid, out_data, $signed(e)); end
      tick();
    end
    tick();
  endtask

  task automatic test_backpressure();
    int exp_d[4] = '{1, 2, 3, 4};
    logic [OUT_W-1:0] e;
    xfer_cnt = 0; done_cnt = 0;
    out_ready = 1'b1;
    begin_tile(1, 2, 3, 4, 0, 1'b0);
    tick();
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'sd2 || out_index !== 2'd1)
        begin failures++; $display("FAIL bp_stall%0d: vld=%b data=%0d idx=%0d required 1 2 1", c, out_valid, out_data, out_index); end
    end
    out_ready = 1'b1;
    for (int k = 1; k < NUM_PE; k++) begin
      e = OUT_W'(exp_d[k]);
      checks++;
      if (out_valid !== 1'b1 || out_data !== e || out_index !== IDX_W'(k))
        begin failures++; $display("FAIL bp_beat%0d: vld=%b data=%0d idx=%0d required 1 %0d %0d", k, out_valid, out_data, out_index, $signed(e), k); end
      tick();
    end
    tick();
    checks++;
    if (xfer_cnt != 4 || done_cnt != 1)
      begin failures++; $display("FAIL bp_counts: xfers=%0d dones=%0d required 4 1", xfer_cnt, done_cnt); end
  endtask

  task automatic test_start_busy();
    int exp_d[4] = '{10, 20, 30, 40};
    logic [OUT_W-1:0] e;
    xfer_cnt = 0; done_cnt = 0; clr_cnt = 0;
    out_ready = 1'b1;
    begin_tile(10, 20, 30, 40, 0, 1'b0);
    tick();
    for (int k = 0; k < NUM_PE; k++) begin
      e = OUT_W'(exp_d[k]);
      checks++;
      if (out_valid !== 1'b1 || out_data !== e)
        begin failures++; $display("FAIL busy_beat%0d: vld=%b data=%0d required 1 %0d", k, out_valid, out_data, $signed(e)); end
      start = (k == 1);
      acc_flat = pack4(-9, -9, -9, -9);
      tick();
      start = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || xfer_cnt != 4 || clr_cnt != 1)
      begin failures++; $display("FAIL busy_counts: done=%b xfers=%0d clears=%0d required 1 4 1", done, xfer_cnt, clr_cnt); end
  endtask

  // Entered with done high: the start must be taken on that very edge.
  task automatic test_back_to_back();
    int exp_d[4] = '{-1, 2, -3, 4};
    logic [OUT_W-1:0] e;
    checks++;
    if (done !== 1'b1)
      begin failures++; $display("FAIL b2b_precond: done=%b required 1", done); end
    begin_tile(-2, 4, -6, 8, 1, 1'b0);
    checks++;
    if (clear_acc_out !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
      begin failures++; $display("FAIL b2b_capture: clr=%b busy=%b done=%b required 1 1 0", clear_acc_out, busy, done); end
    tick();
    for (int k = 0; k < NUM_PE; k++) begin
      e = OUT_W'(exp_d[k]);
      checks++;
      if (out_valid !== 1'b1 || out_data !== e || out_index !== IDX_W'(k))
        begin failures++; $display("FAIL b2b_beat%0d: vld=%b data=%0d idx=%0d required 1 %0d %0d", k, out_valid, out_data, out_index, $signed(e), k); end
      tick();
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    out_ready = 1'b1;
    clr_cnt = 0;
    begin_tile(50, 60, 70, 80, 0, 1'b0);
    tick();
    tick();
    tick();
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, clear_acc_out, out_valid, done, out_last, out_index, out_data} !== '0)
      begin failures++; $display("FAIL midreset_async: busy=%b clr=%b vld=%b done=%b last=%b idx=%0d data=%0d required all 0",
                                 busy, clear_acc_out, out_valid, done, out_last, out_index, out_data); end
    tick();
    reset = 1'b0;
    clr_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || clr_cnt != 0)
        begin failures++; $display("FAIL midreset_quiet%0d: vld=%b busy=%b clears=%0d required 0 0 0", c, out_valid, busy, clr_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sat_round();
    test_relu();
    test_backpressure();
    test_start_busy();
    test_back_to_back();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
